// File: rtl/mips_avalon_pkg.sv
// mips_avalon_pkg: shared arbiter state encoding and the CPU reset vector.
package mips_avalon_pkg;
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
endpackage

// File: rtl/mips_avalon_arb_pick.sv
// mips_avalon_arb_pick: combinational winner select between fetch and data requests.
// ARB_RR_EN selects round-robin tie-break via rr_ptr (1 = data), else fixed DATA_PRIORITY.
module mips_avalon_arb_pick #(
  parameter int DATA_PRIORITY = 1
) (
  input  logic i_req,
  input  logic d_req,
`ifdef ARB_RR_EN
  input  logic rr_ptr,
`endif
  output logic gnt_d
);
`ifdef ARB_RR_EN
  assign gnt_d = d_req & (!i_req | rr_ptr);
`else
  assign gnt_d = d_req & (!i_req | (DATA_PRIORITY != 0));
`endif
endmodule

// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter: two-master (fetch, data) to one-slave Avalon-MM arbiter.
// Define ARB_RR_EN for round-robin tie-break; default is fixed priority.
import mips_avalon_pkg::*;
module mips_avalon_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DATA_PRIORITY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata
);
  arb_state_t state, state_nxt;
  logic d_req, gnt_d, done;
  assign d_req = d_read | d_write;
  assign done = (state != IDLE) & !m_waitrequest;
`ifdef ARB_RR_EN
  logic rr_ptr;
  always_ff @(posedge clk)
    if (reset) rr_ptr <= 1'b1;
    else if (done) rr_ptr <= (state == GNT_I);
  mips_avalon_arb_pick #(.DATA_PRIORITY(DATA_PRIORITY)) u_pick (
    .i_req(i_read), .d_req(d_req), .rr_ptr(rr_ptr), .gnt_d(gnt_d));
`else
  mips_avalon_arb_pick #(.DATA_PRIORITY(DATA_PRIORITY)) u_pick (
    .i_req(i_read), .d_req(d_req), .gnt_d(gnt_d));
`endif
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = !(i_read | d_req) ? IDLE : gnt_d ? GNT_D : GNT_I;
    else if (!m_waitrequest) state_nxt = IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // Slave-facing signals load only from IDLE, so they stay frozen for the whole grant.
  always_ff @(posedge clk)
    if (reset) begin
      m_address    <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
    end else if (state == IDLE) begin
      m_read  <= gnt_d ? (d_read & !d_write) : i_read;
      m_write <= gnt_d & d_write;
      if (i_read | d_req) begin
        m_address    <= gnt_d ? d_address : i_address;
        m_writedata  <= gnt_d ? d_writedata : '0;
        m_byteenable <= gnt_d ? d_byteenable : '1;
      end
    end else if (done) begin
      m_read  <= 1'b0;
      m_write <= 1'b0;
    end
  assign i_waitrequest = i_read & !(state == GNT_I & !m_waitrequest);
  assign d_waitrequest = d_req & !(state == GNT_D & !m_waitrequest);
  assign i_readdata = (state == GNT_I) ? m_readdata : '0;
  assign d_readdata = (state == GNT_D) ? m_readdata : '0;
`ifndef SYNTHESIS
  always @(negedge clk)
    if (!reset && d_read && d_write) $fatal(1, "protocol error: d_read and d_write both high");
`endif
endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// tb_mips_avalon_arbiter: directed bench with a small Avalon slave memory model.
module tb_mips_avalon_arbiter;
  logic clk = 0, reset = 1;
  logic [31:0] i_address = 0, i_readdata, d_address = 0, d_writedata = 0, d_readdata;
  logic i_read = 0, i_waitrequest, d_read = 0, d_write = 0, d_waitrequest;
  logic [3:0] d_byteenable = 0, m_byteenable;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic m_read, m_write, m_waitrequest;
  logic [31:0] mem [0:255];
  int read_delay = 0, cnt = 0, n_chk = 0, n_fail = 0, n;
  always #5 clk = ~clk;
  mips_avalon_arbiter dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata));
  assign m_waitrequest = (m_read | m_write) && (cnt < read_delay);
  assign m_readdata = mem[m_address[9:2]];
  always @(posedge clk) begin
    cnt <= ((m_read | m_write) && m_waitrequest) ? cnt + 1 : 0;
    if (m_write && !m_waitrequest)
      for (int b = 0; b < 4; b++)
        if (m_byteenable[b]) mem[m_address[9:2]][8*b +: 8] <= m_writedata[8*b +: 8];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk); #1;
  endtask
  // Waits for the port's completion, checking held slave signals while the port owns the bus.
  task automatic wait_done(input bit dp, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output int stalls);
    stalls = 0;
    forever begin
      @(negedge clk);
      if ((m_read | m_write) && m_address == a) begin
        check("m_address held", m_address, a);
        if (m_write) begin
          check("m_writedata held", m_writedata, wd);
          check("m_byteenable held", {28'd0, m_byteenable}, {28'd0, be});
        end
      end
      if (!(dp ? d_waitrequest : i_waitrequest)) break;
      stalls++;
      if (stalls > 40) begin
        check("completion timeout", stalls, 0);
        break;
      end
      tick;
    end
  endtask
  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'hA5A50000 | k;
    repeat (3) tick;
    @(negedge clk);
    check("reset m_read", m_read, 0);
    check("reset m_write", m_write, 0);
    check("reset m_address", m_address, 0);
    reset = 0;
    tick;
    @(negedge clk);
    check("idle i_waitrequest", i_waitrequest, 0);
    check("idle d_waitrequest", d_waitrequest, 0);
    // single fetch, slave delay 2
    read_delay = 2;
    tick;
    i_read = 1; i_address = 32'hBFC00000;
    wait_done(0, 32'hBFC00000, 0, 0, n);
    check("fetch stall cycles", n, 3);
    check("fetch i_readdata", i_readdata, 32'hA5A50000);
    check("fetch d_readdata zero", d_readdata, 0);
    tick;
    i_read = 0;
    @(negedge clk);
    check("fetch m_read cleared", m_read, 0);
    // collision, data wins
    read_delay = 1;
    tick;
    i_read = 1; i_address = 32'hBFC00004;
    d_read = 1; d_address = 32'h10;
    wait_done(1, 32'h10, 0, 0, n);
    check("coll data stalls", n, 2);
    check("coll d_readdata", d_readdata, 32'hA5A50004);
    check("coll i still stalled", i_waitrequest, 1);
    check("coll i_readdata zero", i_readdata, 0);
    tick;
    d_read = 0;
    wait_done(0, 32'hBFC00004, 0, 0, n);
    check("coll instr stalls", n, 2);
    check("coll i_readdata", i_readdata, 32'hA5A50001);
    tick;
    i_read = 0;
    // partial write
    mem[8] = 0;
    read_delay = 2;
    tick;
    d_write = 1; d_address = 32'h20; d_writedata = 32'hDEADBEEF; d_byteenable = 4'b0011;
    wait_done(1, 32'h20, 32'hDEADBEEF, 4'b0011, n);
    check("write stalls", n, 3);
    tick;
    d_write = 0;
    @(negedge clk);
    check("write mem word", mem[8], 32'h0000BEEF);
    check("write m_write cleared", m_write, 0);
    read_delay = 0;
    tick;
    d_read = 1;
    wait_done(1, 32'h20, 0, 0, n);
    check("readback d_readdata", d_readdata, 32'h0000BEEF);
    tick;
    d_read = 0;
    // both held continuously: fixed priority starves fetch, round-robin alternates
    reset = 1;
    tick;
    reset = 0;
    i_read = 1; i_address = 32'hBFC00000; d_read = 1; d_address = 32'h10;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
`ifdef ARB_RR_EN
      check("rr d_waitrequest", d_waitrequest, (c % 2 == 0) || ((c / 2) % 2 == 1));
      check("rr i_waitrequest", i_waitrequest, (c % 2 == 0) || ((c / 2) % 2 == 0));
`else
      check("prio d_waitrequest", d_waitrequest, c % 2 == 0);
      check("prio i_waitrequest", i_waitrequest, 1);
`endif
      tick;
    end
    i_read = 0; d_read = 0;
    tick;
    // reset mid-grant abandons the write
    mem[12] = 0;
    read_delay = 5;
    tick;
    d_write = 1; d_address = 32'h30; d_writedata = 32'h12345678; d_byteenable = 4'hF;
    tick;
    @(negedge clk);
    check("midgrant m_write", m_write, 1);
    reset = 1;
    @(negedge clk);
    check("after reset m_write", m_write, 0);
    check("after reset m_address", m_address, 0);
    check("after reset d_waitrequest", d_waitrequest, 1);
    reset = 0; d_write = 0;
    tick;
    @(negedge clk);
    check("abandoned write", mem[12], 0);
    read_delay = 1;
    tick;
    d_write = 1; d_writedata = 32'h0000CAFE;
    wait_done(1, 32'h30, 32'h0000CAFE, 4'hF, n);
    check("fresh write stalls", n, 2);
    tick;
    d_write = 0;
    @(negedge clk);
    check("fresh write mem", mem[12], 32'h0000CAFE);
    // zero-wait back-to-back fetch: completion every other cycle
    read_delay = 0;
    tick;
    i_read = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("b2b i_waitrequest", i_waitrequest, c % 2 == 0);
      tick;
    end
    i_read = 0;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_avalon_arbiter.md
Name: mips_avalon_arbiter

Overview:
- Two-master to one-slave Avalon-MM arbiter in front of the unified memory model.
- Lets the CPU's instruction-fetch port (read-only) and data port (read/write) share one Avalon slave.
- Holds address, writedata and byteenable stable for the whole slave transaction, as the slave requires.
- Returns readdata and completion to the granted requester only.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width for all ports; byteenable width is DATA_W/8.
- DATA_PRIORITY, 1, fixed-priority winner on a tie when ARB_RR_EN is undefined: 1 = data port, 0 = instruction port.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- i_address  in  ADDR_W  instruction fetch address.
- i_read  in  1  instruction read request; held high until i_waitrequest is low.
- i_waitrequest  out  1  stall to the instruction requester.
- i_readdata  out  DATA_W  instruction read data.
- d_address  in  ADDR_W  data address.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_writedata  in  DATA_W  write data.
- d_byteenable  in  DATA_W/8  byte lanes.
- d_waitrequest  out  1  stall to the data requester.
- d_readdata  out  DATA_W  data read data.
- m_address  out  ADDR_W  address to the slave.
- m_read  out  1  read strobe to the slave.
- m_write  out  1  write strobe to the slave.
- m_writedata  out  DATA_W  write data to the slave.
- m_byteenable  out  DATA_W/8  byte lanes to the slave.
- m_waitrequest  in  1  slave stall.
- m_readdata  in  DATA_W  slave read data; valid in the cycle m_waitrequest is low with m_read high.

Behaviour:
- States: IDLE, GNT_I, GNT_D (2-bit encoded).
- Reset (synchronous): state = IDLE. All m_* outputs are registered and reset to 0. Round-robin pointer resets to the data port.
- IDLE:
  - Requests are i_read and (d_read | d_write).
  - If both are pending, pick the winner by DATA_PRIORITY, or by the round-robin rule when ARB_RR_EN is defined.
  - On the clock edge, latch the winner's address, writedata, byteenable, read and write into the m_* registers.
  - Move to GNT_I or GNT_D.
  - No request: stay in IDLE with m_read = m_write = 0.
- GNT_x:
  - m_* registers are frozen (the slave checks that they do not change).
  - The requester's input changes are ignored until completion.
  - Completion is a cycle with m_waitrequest = 0.
  - On completion: the granted requester's waitrequest is 0 for that cycle, its readdata = m_readdata (combinational pass-through), and on the next edge the state returns to IDLE with m_read/m_write cleared.
  - A zero-wait slave therefore gives 2-cycle latency, request to completion.
- Requester waitrequest rule:
  - Combinational: x_waitrequest = x_req & !(state == GNT_x & !m_waitrequest).
  - Result: a requester is stalled in IDLE and while the other port holds the grant.
- Readdata of the non-granted port is 0.
- Back-to-back: after completion, IDLE rearbitrates next cycle. This gives one idle bubble between transactions, by design.
- d_read & d_write both high: protocol error.
  - Simulation-only $fatal at negedge.
  - RTL forwards the write, with m_read = 0.
- A requester that drops its request mid-grant does not abort. The slave transaction completes and the result is discarded.
- Reset asserted in GNT_x: the next edge forces IDLE with m_read = m_write = 0. The slave transaction is abandoned.

Optional Feature:
- ARB_RR_EN defined:
  - Round-robin arbitration on a tie. The pointer toggles to the other port on each completion.
  - DATA_PRIORITY is ignored.
- Undefined:
  - Fixed priority per DATA_PRIORITY; no pointer register.
  - The losing port can starve, which is acceptable for the single-issue CPU.

Decomposition:
- Package mips_avalon_pkg:
  - typedef enum logic[1:0] arb_state_t {IDLE, GNT_I, GNT_D}.
  - localparam RESET_VECTOR = 32'hBFC00000.
- One natural sub-module, mips_avalon_arb_pick: combinational winner select from (i_req, d_req, rr_ptr, DATA_PRIORITY).

Test Plan:
- Single fetch: i_read @0xBFC00000, slave READ_DELAY = 2 → i_waitrequest high for 3 cycles, low in the 4th with i_readdata = memory word. m_address is held at 0xBFC00000 throughout.
- Collision, fixed priority: i_read @0xBFC00004 and d_read @0x10 in the same cycle, DATA_PRIORITY = 1 → data completes first, then the instruction port. i_waitrequest stays high until its own completion.
- Write with byteenable: d_write @0x20, data 0xDEADBEEF, be 4'b0011, starting from 0 → memory word reads back 0x0000BEEF. m_writedata and m_byteenable are stable for the whole transaction.
- Round-robin, ARB_RR_EN: both ports continuously requesting for 8 transactions → grants alternate D, I, D, I, …
- Reset mid-grant: assert reset during GNT_D with m_waitrequest high → next cycle state = IDLE and m_write = 0. A fresh d_write after reset completes normally.
- Zero-wait slave: READ_DELAY = 0, back-to-back i_read → completion every 2 cycles, with an idle bubble each time.
